sdma_sap_dst_walker: RTL and testbench

// Walks every element of one destination feature map, including padding

---
 rtl/sdma_sap_dst_walker.sv | 191 +++++++++++++++++++
 tb/tb_sdma_sap_dst_walker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sdma_sap_dst_walker.sv
// Destination feature-map walker: emits every (c, x, y) coordinate of the padded,
// zero-inserted destination map on a valid/ready handshake, inner axis fastest.
module sdma_sap_dst_walker #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_paddingen,
    input  logic             i_upsampleen,
    input  logic [2:0]       i_paddingaxisbefore,
    input  logic [CNT_W-1:0] i_padleftx,
    input  logic [CNT_W-1:0] i_padrightx,
    input  logic [CNT_W-1:0] i_padlefty,
    input  logic [CNT_W-1:0] i_padrighty,
    input  logic [CNT_W-1:0] i_izx,
    input  logic [CNT_W-1:0] i_izy,
    input  logic [CNT_W-1:0] i_srcfmsc,
    input  logic [CNT_W-1:0] i_srcfmsx,
    input  logic [CNT_W-1:0] i_srcfmsy,
    output logic [CNT_W-1:0] o_sfmsccnt,
    output logic [CNT_W-1:0] o_sfmsxcnt,
    output logic [CNT_W-1:0] o_sfmsycnt,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cfg_err
);

    localparam int EW = CNT_W + 2;
    localparam logic [EW-1:0] EXT_MAX = {2'b01, {CNT_W{1'b0}}};
    localparam logic [1:0] AX_C = 2'd0;
    localparam logic [1:0] AX_X = 2'd1;
    localparam logic [1:0] AX_Y = 2'd2;

    typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             pe_q, ue_q;
    logic [2:0]       axSel_q;
    logic [CNT_W-1:0] padLx_q, padRx_q, padLy_q, padRy_q, izx_q, izy_q;
    logic [CNT_W-1:0] srcC_q, srcX_q, srcY_q;
    logic [EW-1:0]    extIn_q, extMid_q, extOut_q;
    logic [EW-1:0]    extIn_d, extMid_d, extOut_d;
    logic [CNT_W-1:0] cntIn_q, cntMid_q, cntOut_q;
    logic [CNT_W-1:0] cntIn_d, cntMid_d, cntOut_d;
    logic             cfgErr_q, cfgErr_d;
    logic [1:0]       inAx, midAx, outAx;
    logic [CNT_W-1:0] srcIn, srcMid, srcOut;
    logic             inWrap, midWrap, outWrap, lastBeat, badExt;

    // Role decode: which physical axis plays inner, middle and outer.
    always_comb begin
        inAx  = AX_X;
        midAx = AX_Y;
        outAx = AX_C;
        case (axSel_q)
            3'b111: begin inAx = AX_Y; midAx = AX_X; outAx = AX_C; end
            3'b001: begin inAx = AX_C; midAx = AX_X; outAx = AX_Y; end
            3'b110: begin inAx = AX_X; midAx = AX_C; outAx = AX_Y; end
            3'b010: begin inAx = AX_C; midAx = AX_Y; outAx = AX_X; end
            3'b101: begin inAx = AX_Y; midAx = AX_C; outAx = AX_X; end
            default: begin inAx = AX_X; midAx = AX_Y; outAx = AX_C; end
        endcase
    end

    always_comb begin
        srcIn  = (inAx  == AX_C) ? srcC_q : (inAx  == AX_X) ? srcX_q : srcY_q;
        srcMid = (midAx == AX_C) ? srcC_q : (midAx == AX_X) ? srcX_q : srcY_q;
        srcOut = (outAx == AX_C) ? srcC_q : (outAx == AX_X) ? srcX_q : srcY_q;
        extIn_d  = EW'(srcIn)
                 + (pe_q ? EW'(padLx_q) + EW'(padRx_q) : '0)
                 + ((pe_q && ue_q) ? EW'(izx_q) : '0);
        extMid_d = EW'(srcMid)
                 + (pe_q ? EW'(padLy_q) + EW'(padRy_q) : '0)
                 + ((pe_q && ue_q) ? EW'(izy_q) : '0);
        extOut_d = EW'(srcOut);
        badExt   = (extIn_d == '0) || (extMid_d == '0) || (extOut_d == '0)
                 || (extIn_d > EXT_MAX) || (extMid_d > EXT_MAX) || (extOut_d > EXT_MAX);
    end

    assign inWrap   = ({2'b00, cntIn_q}  == extIn_q  - EW'(1));
    assign midWrap  = ({2'b00, cntMid_q} == extMid_q - EW'(1));
    assign outWrap  = ({2'b00, cntOut_q} == extOut_q - EW'(1));
    assign lastBeat = inWrap && midWrap && outWrap;

    always_comb begin
        state_d  = state_q;
        cntIn_d  = cntIn_q;
        cntMid_d = cntMid_q;
        cntOut_d = cntOut_q;
        cfgErr_d = cfgErr_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    cfgErr_d = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (badExt) begin
                    cfgErr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cntIn_d  = '0;
                    cntMid_d = '0;
                    cntOut_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (i_ready) begin
                    if (lastBeat) state_d = DONE;
                    cntIn_d = inWrap ? '0 : cntIn_q + CNT_W'(1);
                    if (inWrap) begin
                        cntMid_d = midWrap ? '0 : cntMid_q + CNT_W'(1);
                        if (midWrap) cntOut_d = outWrap ? '0 : cntOut_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cntIn_q  <= '0;
            cntMid_q <= '0;
            cntOut_q <= '0;
            cfgErr_q <= 1'b0;
            extIn_q  <= '0;
            extMid_q <= '0;
            extOut_q <= '0;
        end else begin
            state_q  <= state_d;
            cntIn_q  <= cntIn_d;
            cntMid_q <= cntMid_d;
            cntOut_q <= cntOut_d;
            cfgErr_q <= cfgErr_d;
            if (state_q == CALC) begin
                extIn_q  <= extIn_d;
                extMid_q <= extMid_d;
                extOut_q <= extOut_d;
            end
        end
    end

    // Config is captured only on an accepted start, so it stays frozen for the walk.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pe_q    <= 1'b0;
            ue_q    <= 1'b0;
            axSel_q <= '0;
            padLx_q <= '0;
            padRx_q <= '0;
            padLy_q <= '0;
            padRy_q <= '0;
            izx_q   <= '0;
            izy_q   <= '0;
            srcC_q  <= '0;
            srcX_q  <= '0;
            srcY_q  <= '0;
        end else if (state_q == IDLE && i_start) begin
            pe_q    <= i_paddingen;
            ue_q    <= i_upsampleen;
            axSel_q <= i_paddingaxisbefore;
            padLx_q <= i_padleftx;
            padRx_q <= i_padrightx;
            padLy_q <= i_padlefty;
            padRy_q <= i_padrighty;
            izx_q   <= i_izx;
            izy_q   <= i_izy;
            srcC_q  <= i_srcfmsc;
            srcX_q  <= i_srcfmsx;
            srcY_q  <= i_srcfmsy;
        end
    end

    assign o_valid    = (state_q == RUN);
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_last     = o_valid && lastBeat;
    assign o_cfg_err  = cfgErr_q;
    assign o_sfmsccnt = (inAx == AX_C) ? cntIn_q : (midAx == AX_C) ? cntMid_q : cntOut_q;
    assign o_sfmsxcnt = (inAx == AX_X) ? cntIn_q : (midAx == AX_X) ? cntMid_q : cntOut_q;
    assign o_sfmsycnt = (inAx == AX_Y) ? cntIn_q : (midAx == AX_Y) ? cntMid_q : cntOut_q;

endmodule

// File: tb/tb_sdma_sap_dst_walker.sv
// Directed bench for sdma_sap_dst_walker: walks several configurations and
// compares every emitted coordinate against a nested-loop enumeration.
module tb_sdma_sap_dst_walker;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_paddingen = 1'b0;
    logic        i_upsampleen = 1'b0;
    logic [2:0]  i_paddingaxisbefore = '0;
    logic [15:0] i_padleftx = '0, i_padrightx = '0, i_padlefty = '0, i_padrighty = '0;
    logic [15:0] i_izx = '0, i_izy = '0;
    logic [15:0] i_srcfmsc = '0, i_srcfmsx = '0, i_srcfmsy = '0;
    logic [15:0] o_sfmsccnt, o_sfmsxcnt, o_sfmsycnt;
    logic        o_valid, o_last, o_busy, o_done, o_cfg_err;
    logic        i_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    sdma_sap_dst_walker #(.CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_paddingen(i_paddingen), .i_upsampleen(i_upsampleen),
        .i_paddingaxisbefore(i_paddingaxisbefore),
        .i_padleftx(i_padleftx), .i_padrightx(i_padrightx),
        .i_padlefty(i_padlefty), .i_padrighty(i_padrighty),
        .i_izx(i_izx), .i_izy(i_izy),
        .i_srcfmsc(i_srcfmsc), .i_srcfmsx(i_srcfmsx), .i_srcfmsy(i_srcfmsy),
        .o_sfmsccnt(o_sfmsccnt), .o_sfmsxcnt(o_sfmsxcnt), .o_sfmsycnt(o_sfmsycnt),
        .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
        .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Loads config, pulses start, scrambles the inputs to prove they were latched,
    // and returns at the negedge where the first beat should be presented.
    task automatic applyStimulus(input logic pe, input logic ue, input logic [2:0] ax,
                                 input logic [15:0] plx, input logic [15:0] prx,
                                 input logic [15:0] ply, input logic [15:0] pry,
                                 input logic [15:0] izx, input logic [15:0] izy,
                                 input logic [15:0] c, input logic [15:0] x, input logic [15:0] y);
        i_paddingen = pe; i_upsampleen = ue; i_paddingaxisbefore = ax;
        i_padleftx = plx; i_padrightx = prx; i_padlefty = ply; i_padrighty = pry;
        i_izx = izx; i_izy = izy;
        i_srcfmsc = c; i_srcfmsx = x; i_srcfmsy = y;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_srcfmsc = 16'd7; i_srcfmsx = 16'd0; i_srcfmsy = 16'd9;
        i_padleftx = 16'd3; i_izx = 16'd4; i_paddingaxisbefore = 3'b010;
        checkOutput("calcValid", o_valid, 0);
        checkOutput("calcBusy", o_busy, 1);
        checkOutput("calcErrClr", o_cfg_err, 0);
        @(negedge i_clk);
    endtask

    task automatic runWalk(input string name, input int eIn, input int eMid, input int eOut,
                           input int inAx, input int midAx, input int outAx, input bit randReady);
        int total = eIn * eMid * eOut;
        int n = 0;
        int cyc = 0;
        int limit = 4 * total + 20;
        int cval[3];
        logic rdy;
        while (n < total && cyc < limit) begin
            cval[inAx]  = n % eIn;
            cval[midAx] = (n / eIn) % eMid;
            cval[outAx] = n / (eIn * eMid);
            checkOutput({name, ".valid"}, o_valid, 1);
            checkOutput({name, ".c"}, o_sfmsccnt, cval[0]);
            checkOutput({name, ".x"}, o_sfmsxcnt, cval[1]);
            checkOutput({name, ".y"}, o_sfmsycnt, cval[2]);
            checkOutput({name, ".last"}, o_last, (n == total - 1) ? 1 : 0);
            rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            i_ready = rdy;
            if (o_valid && rdy) n++;
            @(negedge i_clk);
            cyc++;
        end
        checkOutput({name, ".beats"}, n, total);
        checkOutput({name, ".done"}, o_done, 1);
        checkOutput({name, ".doneValid"}, o_valid, 0);
        checkOutput({name, ".err"}, o_cfg_err, 0);
        @(negedge i_clk);
        checkOutput({name, ".donePulse"}, o_done, 0);
        checkOutput({name, ".idleBusy"}, o_busy, 0);
        i_ready = 1'b0;
    endtask

    task automatic runErr(input string name);
        checkOutput({name, ".valid"}, o_valid, 0);
        checkOutput({name, ".done"}, o_done, 1);
        checkOutput({name, ".err"}, o_cfg_err, 1);
        @(negedge i_clk);
        checkOutput({name, ".donePulse"}, o_done, 0);
        checkOutput({name, ".errSticky"}, o_cfg_err, 1);
        checkOutput({name, ".busy"}, o_busy, 0);
    endtask

    initial begin
        @(negedge i_clk);
        @(negedge i_clk);
        checkOutput("rst.valid", o_valid, 0);
        checkOutput("rst.busy", o_busy, 0);
        checkOutput("rst.done", o_done, 0);
        checkOutput("rst.err", o_cfg_err, 0);
        checkOutput("rst.cnt", {o_sfmsccnt, o_sfmsxcnt}, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        $display("[TB] walk1: no padding, x fastest");
        applyStimulus(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd2, 16'd3, 16'd2);
        runWalk("walk1", 3, 2, 2, 1, 2, 0, 0);

        $display("[TB] walk2: padding x 1/1, y 1/0");
        applyStimulus(1, 0, 3'b000, 16'd1, 16'd1, 16'd1, 16'd0, 16'd5, 16'd5, 16'd1, 16'd2, 16'd2);
        runWalk("walk2", 4, 3, 1, 1, 2, 0, 0);

        $display("[TB] walk3: upsample, axis 111");
        applyStimulus(1, 1, 3'b111, 0, 0, 0, 0, 16'd1, 16'd2, 16'd1, 16'd2, 16'd3);
        runWalk("walk3", 4, 4, 1, 2, 1, 0, 0);

        $display("[TB] walk4: random ready, axis 001, insert-zero gated off");
        applyStimulus(0, 1, 3'b001, 16'd2, 16'd2, 16'd2, 16'd2, 16'd5, 16'd5, 16'd3, 16'd2, 16'd2);
        runWalk("walk4", 3, 2, 2, 0, 1, 2, 1);

        $display("[TB] err1: zero x size");
        applyStimulus(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd2, 16'd0, 16'd2);
        runErr("err1");

        $display("[TB] err2: extent above 2^CNT_W");
        applyStimulus(1, 0, 3'b000, 16'd1, 16'd1, 0, 0, 0, 0, 16'd1, 16'hFFFF, 16'd1);
        runErr("err2");

        $display("[TB] rst: reset mid-walk then restart");
        applyStimulus(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd2, 16'd3, 16'd2);
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_start = (k == 1);
            @(negedge i_clk);
        end
        i_start = 1'b0;
        checkOutput("rst5.valid", o_valid, 1);
        checkOutput("rst5.x", o_sfmsxcnt, 2);
        checkOutput("rst5.y", o_sfmsycnt, 1);
        checkOutput("rst5.c", o_sfmsccnt, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("rstMid.valid", o_valid, 0);
        checkOutput("rstMid.done", o_done, 0);
        checkOutput("rstMid.busy", o_busy, 0);
        i_rst = 1'b0;
        i_ready = 1'b0;
        @(negedge i_clk);
        applyStimulus(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd2, 16'd3, 16'd2);
        runWalk("restart", 3, 2, 2, 1, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
